// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared definitions for the host-side memory loader.
//   OP_*            command opcodes carried on cmd_op
//   state_t         loader FSM state
//   RD_W            read FIFO entry width (64-bit word + last flag)
//   *_STEP_DEF      default byte increments per imem/dmem word
package mem_loader_pkg;
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WR_IMEM = 3'd1;
  localparam logic [2:0] OP_WR_DMEM = 3'd2;
  localparam logic [2:0] OP_RD_IMEM = 3'd3;
  localparam logic [2:0] OP_RD_DMEM = 3'd4;
  localparam logic [2:0] OP_RUN     = 3'd5;
  localparam logic [2:0] OP_HALT    = 3'd6;
  localparam int unsigned IMEM_STEP_DEF = 4;
  localparam int unsigned DMEM_STEP_DEF = 8;
  localparam int unsigned RD_W = 65;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;
  function automatic logic is_mem_op(input logic [2:0] op);
    return op inside {OP_WR_IMEM, OP_WR_DMEM, OP_RD_IMEM, OP_RD_DMEM};
  endfunction
  function automatic logic is_imem_op(input logic [2:0] op);
    return op == OP_WR_IMEM || op == OP_RD_IMEM;
  endfunction
  function automatic logic is_wr_op(input logic [2:0] op);
    return op == OP_WR_IMEM || op == OP_WR_DMEM;
  endfunction
endpackage

// File: rtl/loader_rd_fifo.sv
// loader_rd_fifo: 2-entry synchronous FIFO buffering read words with their last flag.
//   clk, arst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push_i/push_data_i  write an entry (ignored when full)
//   pop_i/pop_data_o    drop the head entry (ignored when empty); head is always visible
//   full_o, empty_o, count_o  occupancy status
module loader_rd_fifo
  import mem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            arst_n,
  input  logic            push_i,
  input  logic [RD_W-1:0] push_data_i,
  input  logic            pop_i,
  output logic [RD_W-1:0] pop_data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [1:0]      count_o
);
  logic [RD_W-1:0] mem_q [2];
  logic            wptr_q, rptr_q;
  logic [1:0]      cnt_q;
  logic            do_push, do_pop;
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign full_o     = cnt_q == 2'd2;
  assign empty_o    = cnt_q == 2'd0;
  assign count_o    = cnt_q;
  assign pop_data_o = mem_q[rptr_q];
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) mem_q[wptr_q] <= push_data_i;
      if (do_push) wptr_q <= !wptr_q;
      if (do_pop) rptr_q <= !rptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/mem_loader.sv
// mem_loader: host-side initiator that bursts writes/reads into the CPU's imem and dmem
// external ports and owns the CPU enable line.
//   clk, arst_n                     clock, asynchronous active-low reset
//   cmd_valid/ready/op/addr/len     command stream (accepted only while idle)
//   wr_valid/ready/data             write-data beats for WR_* bursts
//   rd_valid/ready/data/last        read-data beats for RD_* bursts
//   addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext            imem port (32-bit words)
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2/rdata_ext_2  dmem port (64-bit words)
//   cpu_enable                      core runs while high; memory bursts are refused then
//   busy                            a burst is in progress
//   err                             one-cycle pulse when a burst command is refused
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned IMEM_STEP = IMEM_STEP_DEF,
  parameter int unsigned DMEM_STEP = DMEM_STEP_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [63:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [63:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [63:0]      rd_data,
  output logic             rd_last,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  input  logic [31:0]      rdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             cpu_enable,
  output logic             busy,
  output logic             err
);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  state_t          state_q, state_d;
  logic [63:0]     addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] ret_q, ret_d;
  logic            imem_q, imem_d;
  logic            cpu_en_q, cpu_en_d;
  logic            err_q, err_d;
  logic            pend_q, pend_d;
  logic [63:0]     addr_ext_q, addr_ext_d, addr_ext_2_q, addr_ext_2_d;
  logic            wen_ext_q, wen_ext_d, ren_ext_q, ren_ext_d;
  logic            wen_ext_2_q, wen_ext_2_d, ren_ext_2_q, ren_ext_2_d;
  logic [31:0]     wdata_ext_q, wdata_ext_d;
  logic [63:0]     wdata_ext_2_q, wdata_ext_2_d;
  logic            cmd_fire, wr_fire, issue, pop, push;
  logic [63:0]     step, push_word;
  logic [RD_W-1:0] head;
  logic            fifo_full, fifo_empty;
  logic [1:0]      fifo_cnt;
  logic [2:0]      occ;
  // Async reset also gates cmd_ready so every output reads 0 while reset is held.
  assign cmd_ready = state_q == S_IDLE && arst_n;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_ready  = state_q == S_WRITE && rem_q != '0;
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_valid  = !fifo_empty;
  assign pop       = rd_valid && rd_ready;
  assign push      = pend_q;
  assign step      = imem_q ? 64'(IMEM_STEP) : 64'(DMEM_STEP);
  assign push_word = imem_q ? {32'b0, rdata_ext} : rdata_ext_2;
  // Words held or owed to the FIFO: stored entries, the ren on the port, and the word on the
  // return bus. A pop this cycle frees a slot before any newly issued word can land.
  assign occ   = {1'b0, fifo_cnt} + {2'b0, ren_ext_q || ren_ext_2_q} + {2'b0, pend_q};
  assign issue = state_q == S_READ && rem_q != '0 && !fifo_full && occ < 3'd2 + {2'b0, pop};
  assign rd_data     = head[63:0];
  assign rd_last     = head[64];
  assign addr_ext    = addr_ext_q;
  assign wen_ext     = wen_ext_q;
  assign ren_ext     = ren_ext_q;
  assign wdata_ext   = wdata_ext_q;
  assign addr_ext_2  = addr_ext_2_q;
  assign wen_ext_2   = wen_ext_2_q;
  assign ren_ext_2   = ren_ext_2_q;
  assign wdata_ext_2 = wdata_ext_2_q;
  assign cpu_enable  = cpu_en_q;
  assign busy        = state_q != S_IDLE;
  assign err         = err_q;
  loader_rd_fifo u_fifo (
    .clk         (clk),
    .arst_n      (arst_n),
    .push_i      (push),
    .push_data_i ({ret_q == ONE, push_word}),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    ret_d         = push ? ret_q - ONE : ret_q;
    imem_d        = imem_q;
    cpu_en_d      = cpu_en_q;
    err_d         = 1'b0;
    pend_d        = ren_ext_q || ren_ext_2_q;
    addr_ext_d    = addr_ext_q;
    addr_ext_2_d  = addr_ext_2_q;
    wdata_ext_d   = wdata_ext_q;
    wdata_ext_2_d = wdata_ext_2_q;
    wen_ext_d     = imem_q && wr_fire;
    ren_ext_d     = imem_q && issue;
    wen_ext_2_d   = !imem_q && wr_fire;
    ren_ext_2_d   = !imem_q && issue;
    if (cmd_fire && cmd_op == OP_RUN) cpu_en_d = 1'b1;
    if (cmd_fire && cmd_op == OP_HALT) cpu_en_d = 1'b0;
    if (cmd_fire && is_mem_op(cmd_op) && cpu_en_q) err_d = 1'b1;
    if (cmd_fire && is_mem_op(cmd_op) && !cpu_en_q && cmd_len != '0) begin
      addr_d  = cmd_addr;
      rem_d   = cmd_len;
      ret_d   = cmd_len;
      imem_d  = is_imem_op(cmd_op);
      state_d = is_wr_op(cmd_op) ? S_WRITE : S_READ;
    end
    if (wr_fire || issue) begin
      addr_d       = addr_q + step;
      rem_d        = rem_q - ONE;
      addr_ext_d   = imem_q ? addr_q : addr_ext_q;
      addr_ext_2_d = imem_q ? addr_ext_2_q : addr_q;
    end
    if (wr_fire && imem_q) wdata_ext_d = wr_data[31:0];
    if (wr_fire && !imem_q) wdata_ext_2_d = wr_data;
    // Stay in WRITE through the final strobe so cmd_ready rises only after it.
    if (state_q == S_WRITE && rem_q == '0) state_d = S_IDLE;
    if (state_q == S_READ && pop && rd_last) state_d = S_IDLE;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      ret_q         <= '0;
      imem_q        <= 1'b0;
      cpu_en_q      <= 1'b0;
      err_q         <= 1'b0;
      pend_q        <= 1'b0;
      addr_ext_q    <= '0;
      addr_ext_2_q  <= '0;
      wen_ext_q     <= 1'b0;
      ren_ext_q     <= 1'b0;
      wen_ext_2_q   <= 1'b0;
      ren_ext_2_q   <= 1'b0;
      wdata_ext_q   <= '0;
      wdata_ext_2_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      ret_q         <= ret_d;
      imem_q        <= imem_d;
      cpu_en_q      <= cpu_en_d;
      err_q         <= err_d;
      pend_q        <= pend_d;
      addr_ext_q    <= addr_ext_d;
      addr_ext_2_q  <= addr_ext_2_d;
      wen_ext_q     <= wen_ext_d;
      ren_ext_q     <= ren_ext_d;
      wen_ext_2_q   <= wen_ext_2_d;
      ren_ext_2_q   <= ren_ext_2_d;
      wdata_ext_q   <= wdata_ext_d;
      wdata_ext_2_q <= wdata_ext_2_d;
    end
  end
endmodule
